// File: rtl/r_ecc_chk_pipe.sv
// SEC-DED read-side check/correct pipeline: input stage S0, combinational check,
// registered output stage S1, with saturating error counters and a first-error log.
module r_ecc_chk_pipe #(
    parameter int WDTH  = 34,
    parameter int CBTS  = 7,
    parameter int AWDTH = 10,
    parameter int CNTW  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic [AWDTH-1:0] i_addr,
    input  logic [WDTH-1:0]  i_data,
    input  logic [CBTS-1:0]  i_chk,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [WDTH-1:0]  o_data,
    output logic             o_sb_err,
    output logic             o_mb_err,
    output logic [CNTW-1:0]  o_sb_cnt,
    output logic [CNTW-1:0]  o_mb_cnt,
    input  logic             i_cnt_clr,
    output logic             o_log_vld,
    output logic             o_log_mb,
    output logic [AWDTH-1:0] o_log_addr,
    output logic [CBTS-1:0]  o_log_synd,
    input  logic             i_log_clr
);
    localparam int SW = CBTS - 1;
    localparam logic [SW-1:0]   ONE_S = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] ONE_C = {{(CNTW-1){1'b0}}, 1'b1};

    // Extended Hamming layout shared with the write-side generator: data bit idx
    // sits at the idx-th non-power-of-two codeword position, check bit j at 2^j,
    // top check bit is overall parity.
    function automatic logic [SW-1:0] dpos(input int idx);
        logic [SW-1:0] r;
        int            cnt;
        r   = '0;
        cnt = 0;
        for (int p = 3; p < (1 << SW); p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) r = p[SW-1:0];
                cnt++;
            end
        end
        return r;
    endfunction

    logic             s0_vld_q;
    logic [AWDTH-1:0] s0_addr_q;
    logic [WDTH-1:0]  s0_data_q;
    logic [CBTS-1:0]  s0_chk_q;
    logic             vld_q, sb_q, mb_q;
    logic [WDTH-1:0]  data_q;
    logic [CNTW-1:0]  sb_cnt_q, sb_cnt_d, mb_cnt_q, mb_cnt_d;
    logic             log_vld_q, log_vld_d, log_mb_q, log_mb_d;
    logic [AWDTH-1:0] log_addr_q, log_addr_d;
    logic [CBTS-1:0]  log_synd_q, log_synd_d;

    logic s1_adv, s0_adv, acc;
    assign s1_adv = !vld_q || i_rdy;
    assign s0_adv = s0_vld_q && s1_adv;
    assign o_rdy  = !s0_vld_q || s1_adv;
    assign acc    = i_vld && o_rdy;

    logic [SW-1:0]   syn;
    logic            par, data_hit, chk_hit, sb, mb;
    logic [WDTH-1:0] cor;
    logic [CBTS-1:0] synd;

    always_comb begin
        syn = s0_chk_q[SW-1:0];
        for (int i = 0; i < WDTH; i++)
            if (s0_data_q[i]) syn = syn ^ dpos(i);
        par      = ^{s0_data_q, s0_chk_q};
        data_hit = 1'b0;
        cor      = s0_data_q;
        for (int i = 0; i < WDTH; i++) begin
            if (syn == dpos(i)) begin
                data_hit = 1'b1;
                if (par) cor[i] = ~s0_data_q[i];
            end
        end
        // zero or power-of-two syndrome with odd parity points at a check bit
        chk_hit = ((syn & (syn - ONE_S)) == '0);
        sb      = par && (data_hit || chk_hit);
        mb      = (!par && (syn != '0)) || (par && !data_hit && !chk_hit);
        synd    = {par, syn};
    end

    logic sb_inc, mb_inc, err;
    always_comb begin
        sb_inc   = s0_adv && sb;
        mb_inc   = s0_adv && mb;
        err      = sb_inc || mb_inc;
        sb_cnt_d = sb_cnt_q;
        mb_cnt_d = mb_cnt_q;
        if (i_cnt_clr) begin
            sb_cnt_d = sb_inc ? ONE_C : '0;
            mb_cnt_d = mb_inc ? ONE_C : '0;
        end else begin
            if (sb_inc && (sb_cnt_q != '1)) sb_cnt_d = sb_cnt_q + ONE_C;
            if (mb_inc && (mb_cnt_q != '1)) mb_cnt_d = mb_cnt_q + ONE_C;
        end

        log_vld_d  = log_vld_q;
        log_mb_d   = log_mb_q;
        log_addr_d = log_addr_q;
        log_synd_d = log_synd_q;
        if (err && (!log_vld_q || i_log_clr || (mb && !log_mb_q))) begin
            log_vld_d  = 1'b1;
            log_mb_d   = mb;
            log_addr_d = s0_addr_q;
            log_synd_d = synd;
        end else if (i_log_clr) begin
            log_vld_d  = 1'b0;
            log_mb_d   = 1'b0;
            log_addr_d = '0;
            log_synd_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s0_vld_q   <= 1'b0;
            s0_addr_q  <= '0;
            s0_data_q  <= '0;
            s0_chk_q   <= '0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            sb_q       <= 1'b0;
            mb_q       <= 1'b0;
            sb_cnt_q   <= '0;
            mb_cnt_q   <= '0;
            log_vld_q  <= 1'b0;
            log_mb_q   <= 1'b0;
            log_addr_q <= '0;
            log_synd_q <= '0;
        end else begin
            if (acc) begin
                s0_vld_q  <= 1'b1;
                s0_addr_q <= i_addr;
                s0_data_q <= i_data;
                s0_chk_q  <= i_chk;
            end else if (s0_adv) begin
                s0_vld_q  <= 1'b0;
            end
            if (s1_adv) vld_q <= s0_vld_q;
            if (s0_adv) begin
                data_q <= cor;
                sb_q   <= sb;
                mb_q   <= mb;
            end
            sb_cnt_q   <= sb_cnt_d;
            mb_cnt_q   <= mb_cnt_d;
            log_vld_q  <= log_vld_d;
            log_mb_q   <= log_mb_d;
            log_addr_q <= log_addr_d;
            log_synd_q <= log_synd_d;
        end
    end

    assign o_vld      = vld_q;
    assign o_data     = data_q;
    assign o_sb_err   = sb_q;
    assign o_mb_err   = mb_q;
    assign o_sb_cnt   = sb_cnt_q;
    assign o_mb_cnt   = mb_cnt_q;
    assign o_log_vld  = log_vld_q;
    assign o_log_mb   = log_mb_q;
    assign o_log_addr = log_addr_q;
    assign o_log_synd = log_synd_q;
endmodule

// File: tb/tb_r_ecc_chk_pipe.sv
// Scoreboard bench for r_ecc_chk_pipe: encodes words with its own Hamming model,
// injects bit flips, and checks data, flags, counters and log per scenario.
module tb_r_ecc_chk_pipe;
    localparam int W = 34, C = 7, AW = 10, CN = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n, i_vld, o_rdy, o_vld, i_rdy;
    logic [AW-1:0] i_addr, o_log_addr;
    logic [W-1:0]  i_data, o_data;
    logic [C-1:0]  i_chk, o_log_synd;
    logic          o_sb_err, o_mb_err, i_cnt_clr, o_log_vld, o_log_mb, i_log_clr;
    logic [CN-1:0] o_sb_cnt, o_mb_cnt;

    always #5 i_clk = ~i_clk;

    r_ecc_chk_pipe #(.WDTH(W), .CBTS(C), .AWDTH(AW), .CNTW(CN)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(i_vld), .o_rdy(o_rdy),
        .i_addr(i_addr), .i_data(i_data), .i_chk(i_chk), .o_vld(o_vld),
        .i_rdy(i_rdy), .o_data(o_data), .o_sb_err(o_sb_err), .o_mb_err(o_mb_err),
        .o_sb_cnt(o_sb_cnt), .o_mb_cnt(o_mb_cnt), .i_cnt_clr(i_cnt_clr),
        .o_log_vld(o_log_vld), .o_log_mb(o_log_mb), .o_log_addr(o_log_addr),
        .o_log_synd(o_log_synd), .i_log_clr(i_log_clr)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  raw;
        logic [C-1:0]  chk;
        logic [W-1:0]  exp;
        logic          sb;
        logic          mb;
        bit            cclr;
        bit            lclr;
    } word_t;
    typedef struct {
        logic [W-1:0] data;
        logic         sb;
        logic         mb;
        int           acc;
    } exp_t;

    word_t stim[$];
    exp_t  sbq[$];
    int    n_cmp = 0, n_err = 0;
    localparam logic [W-1:0] D0 = 34'h0_1234_5678;

    // codeword position of data bit k: k-th position that is not a power of two
    function automatic int bpos(input int k);
        int p;
        p = 2;
        for (int i = 0; i <= k; i++) begin
            p = p + 1;
            while ((p & (p - 1)) == 0) p = p + 1;
        end
        return p;
    endfunction

    function automatic logic [C-1:0] enc(input logic [W-1:0] d);
        logic [C-1:0] c;
        int           p;
        c = '0;
        for (int i = 0; i < W; i++) begin
            p = bpos(i);
            if (d[i])
                for (int j = 0; j < C - 1; j++)
                    if (p[j]) c[j] = ~c[j];
        end
        c[C-1] = ^{d, c[C-2:0]};
        return c;
    endfunction

    function automatic word_t mk(input logic [AW-1:0] a, input logic [W-1:0] d,
                                 input logic [W-1:0] df, input logic [C-1:0] cf,
                                 input bit cc, input bit lc);
        word_t w;
        int    nf;
        nf     = $countones(df) + $countones(cf);
        w.addr = a;
        w.raw  = d ^ df;
        w.chk  = enc(d) ^ cf;
        w.exp  = (nf >= 2) ? (d ^ df) : d;
        w.sb   = (nf == 1);
        w.mb   = (nf >= 2);
        w.cclr = cc;
        w.lclr = lc;
        return w;
    endfunction

    // Drives stim[] through the DUT and scoreboards every output word.
    task automatic run_words(input int lo_start, input int lo_len, input bit lat);
        int           cyc, idx, n;
        bit           hold, cc_nxt, lc_nxt;
        logic [W-1:0] pd;
        logic         psb, pmb;
        exp_t         e;
        n = stim.size(); idx = 0; cyc = 0; hold = 0; cc_nxt = 0; lc_nxt = 0;
        pd = '0; psb = 0; pmb = 0;
        while ((idx < n || sbq.size() != 0) && cyc < 100) begin
            @(negedge i_clk);
            i_vld = (idx < n);
            if (idx < n) begin
                i_addr = stim[idx].addr; i_data = stim[idx].raw; i_chk = stim[idx].chk;
            end
            i_rdy     = !(cyc >= lo_start && cyc < lo_start + lo_len);
            i_cnt_clr = cc_nxt; i_log_clr = lc_nxt; cc_nxt = 0; lc_nxt = 0;
            #1;
            n_cmp++;
            if (o_rdy !== (sbq.size() < 2 || i_rdy)) begin
                n_err++;
                $display("FAIL o_rdy cyc %0d: got %b want %b", cyc, o_rdy, (sbq.size() < 2 || i_rdy));
            end
            if (hold) begin
                n_cmp++;
                if ({o_data, o_sb_err, o_mb_err} !== {pd, psb, pmb}) begin
                    n_err++;
                    $display("FAIL hold cyc %0d: got %h/%b%b want %h/%b%b", cyc, o_data, o_sb_err, o_mb_err, pd, psb, pmb);
                end
            end
            hold = o_vld && !i_rdy; pd = o_data; psb = o_sb_err; pmb = o_mb_err;
            if (o_vld && i_rdy) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL extra word: got %h want none", o_data);
                end else begin
                    e = sbq.pop_front();
                    if ({o_data, o_sb_err, o_mb_err} !== {e.data, e.sb, e.mb}) begin
                        n_err++;
                        $display("FAIL word: got %h sb%b mb%b want %h sb%b mb%b", o_data, o_sb_err, o_mb_err, e.data, e.sb, e.mb);
                    end
                    if (lat) begin
                        n_cmp++;
                        if (cyc - e.acc != 2) begin
                            n_err++;
                            $display("FAIL latency: got %0d want 2", cyc - e.acc);
                        end
                    end
                end
            end
            if (i_vld && o_rdy) begin
                sbq.push_back('{stim[idx].exp, stim[idx].sb, stim[idx].mb, cyc});
                cc_nxt = stim[idx].cclr; lc_nxt = stim[idx].lclr;
                idx++;
            end
            cyc++;
        end
        if (cyc >= 100) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: got %0d pending want 0", sbq.size());
        end
        @(negedge i_clk);
        i_vld = 0; i_cnt_clr = 0; i_log_clr = 0; i_rdy = 1;
        #1;
        stim.delete();
    endtask

    task automatic test_reset();
        i_rst_n = 0; i_vld = 0; i_rdy = 1; i_addr = '0; i_data = '0; i_chk = '0;
        i_cnt_clr = 0; i_log_clr = 0;
        repeat (2) @(negedge i_clk);
        #1;
        n_cmp++;
        if ({o_vld, o_rdy, o_sb_err, o_mb_err} !== 4'b0100) begin
            n_err++; $display("FAIL reset hs: got %b want 0100", {o_vld, o_rdy, o_sb_err, o_mb_err});
        end
        n_cmp++;
        if (o_data !== '0) begin n_err++; $display("FAIL reset data: got %h want 0", o_data); end
        n_cmp++;
        if ({o_sb_cnt, o_mb_cnt} !== '0) begin
            n_err++; $display("FAIL reset cnt: got %h/%h want 0/0", o_sb_cnt, o_mb_cnt);
        end
        n_cmp++;
        if ({o_log_vld, o_log_mb, o_log_addr, o_log_synd} !== '0) begin
            n_err++; $display("FAIL reset log: got %b %b %h %h want 0", o_log_vld, o_log_mb, o_log_addr, o_log_synd);
        end
        @(negedge i_clk);
        i_rst_n = 1;
    endtask

    task automatic test_clean();
        for (int i = 0; i < 4; i++) stim.push_back(mk(AW'(i), D0 + W'(i * 3), '0, '0, 0, 0));
        run_words(0, 0, 1);
        n_cmp++;
        if ({o_sb_cnt, o_mb_cnt, o_log_vld} !== '0) begin
            n_err++; $display("FAIL clean status: got %h/%h/%b want 0", o_sb_cnt, o_mb_cnt, o_log_vld);
        end
    endtask

    task automatic test_sb();
        logic [C-2:0] sp;
        int           q;
        q  = bpos(5);
        sp = q[C-2:0];
        stim.push_back(mk(10'h2A, D0, W'(1) << 5, '0, 0, 0));
        run_words(0, 0, 1);
        n_cmp++;
        if ({o_sb_cnt, o_mb_cnt} !== {4'd1, 4'd0}) begin
            n_err++; $display("FAIL sb cnt: got %h/%h want 1/0", o_sb_cnt, o_mb_cnt);
        end
        n_cmp++;
        if ({o_log_vld, o_log_mb, o_log_addr} !== {1'b1, 1'b0, 10'h2A}) begin
            n_err++; $display("FAIL sb log: got %b %b %h want 1 0 2a", o_log_vld, o_log_mb, o_log_addr);
        end
        n_cmp++;
        if (o_log_synd !== {1'b1, sp} || o_log_synd == '0) begin
            n_err++; $display("FAIL sb synd: got %h want %h", o_log_synd, {1'b1, sp});
        end
    endtask

    task automatic test_mb();
        stim.push_back(mk(10'h3F, D0, (W'(1) << 3) | (W'(1) << 9), '0, 0, 0));
        run_words(0, 0, 0);
        n_cmp++;
        if ({o_sb_cnt, o_mb_cnt} !== {4'd1, 4'd1}) begin
            n_err++; $display("FAIL mb cnt: got %h/%h want 1/1", o_sb_cnt, o_mb_cnt);
        end
        n_cmp++;
        if ({o_log_vld, o_log_mb, o_log_addr} !== {1'b1, 1'b1, 10'h3F}) begin
            n_err++; $display("FAIL mb log: got %b %b %h want 1 1 3f", o_log_vld, o_log_mb, o_log_addr);
        end
    endtask

    task automatic test_back_to_back();
        stim.push_back(mk(10'h100, 34'h2_AAAA_5555, '0, '0, 0, 0));
        stim.push_back(mk(10'h101, 34'h1_0F0F_F0F0, '0, C'(1) << 2, 0, 0));
        stim.push_back(mk(10'h102, 34'h3_1357_9BDF, (W'(1) << 0) | (W'(1) << 33), '0, 0, 0));
        run_words(1, 5, 0);
        n_cmp++;
        if ({o_sb_cnt, o_mb_cnt} !== {4'd2, 4'd2}) begin
            n_err++; $display("FAIL bp cnt: got %h/%h want 2/2", o_sb_cnt, o_mb_cnt);
        end
        n_cmp++;
        if ({o_log_mb, o_log_addr} !== {1'b1, 10'h3F}) begin
            n_err++; $display("FAIL bp log: got %b %h want 1 3f", o_log_mb, o_log_addr);
        end
    endtask

    task automatic test_sat_clear();
        @(negedge i_clk); i_cnt_clr = 1;
        @(negedge i_clk); i_cnt_clr = 0;
        #1;
        n_cmp++;
        if ({o_sb_cnt, o_mb_cnt} !== '0) begin
            n_err++; $display("FAIL cnt clr: got %h/%h want 0/0", o_sb_cnt, o_mb_cnt);
        end
        for (int i = 0; i < 17; i++)
            stim.push_back(mk(AW'(i), W'(i * 77 + 3), W'(1) << (i % W), '0, 0, 0));
        run_words(0, 0, 0);
        n_cmp++;
        if ({o_sb_cnt, o_mb_cnt} !== {4'd15, 4'd0}) begin
            n_err++; $display("FAIL sat: got %h/%h want f/0", o_sb_cnt, o_mb_cnt);
        end
        stim.push_back(mk(10'h050, D0, W'(1) << 20, '0, 1, 0));
        run_words(0, 0, 0);
        n_cmp++;
        if (o_sb_cnt !== 4'd1) begin n_err++; $display("FAIL clr+inc: got %h want 1", o_sb_cnt); end
        stim.push_back(mk(10'h155, D0, (W'(1) << 1) | (W'(1) << 30), '0, 0, 1));
        run_words(0, 0, 0);
        n_cmp++;
        if ({o_log_vld, o_log_mb, o_log_addr, o_mb_cnt} !== {1'b1, 1'b1, 10'h155, 4'd1}) begin
            n_err++; $display("FAIL logclr+mb: got %b %b %h %h want 1 1 155 1", o_log_vld, o_log_mb, o_log_addr, o_mb_cnt);
        end
        @(negedge i_clk); i_log_clr = 1;
        @(negedge i_clk); i_log_clr = 0;
        #1;
        n_cmp++;
        if (o_log_vld !== 1'b0) begin n_err++; $display("FAIL log clr: got %b want 0", o_log_vld); end
    endtask

    task automatic test_reset_mid();
        word_t a, b;
        a = mk(10'h0AA, D0, (W'(1) << 4) | (W'(1) << 8), '0, 0, 0);
        b = mk(10'h0AB, 34'h0_DEAD_BEEF, '0, '0, 0, 0);
        @(negedge i_clk);
        i_rdy = 0; i_vld = 1; i_addr = a.addr; i_data = a.raw; i_chk = a.chk;
        @(negedge i_clk);
        i_addr = b.addr; i_data = b.raw; i_chk = b.chk;
        @(negedge i_clk);
        i_vld = 0;
        #1;
        n_cmp++;
        if ({o_vld, o_rdy, o_log_vld} !== 3'b101) begin
            n_err++; $display("FAIL full: got %b want 101", {o_vld, o_rdy, o_log_vld});
        end
        i_rst_n = 0;
        #1;
        n_cmp++;
        if ({o_vld, o_rdy, o_sb_err, o_mb_err, o_data} !== {4'b0100, W'(0)}) begin
            n_err++; $display("FAIL async rst: got %b %h want 0100 0", {o_vld, o_rdy, o_sb_err, o_mb_err}, o_data);
        end
        n_cmp++;
        if ({o_sb_cnt, o_mb_cnt, o_log_vld, o_log_mb, o_log_addr, o_log_synd} !== '0) begin
            n_err++; $display("FAIL async rst status: got %h %h %b %h want 0", o_sb_cnt, o_mb_cnt, o_log_vld, o_log_addr);
        end
        sbq.delete();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1; i_rdy = 1;
        stim.push_back(mk(10'h001, 34'h0_0000_1111, '0, '0, 0, 0));
        run_words(0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_sb();
        test_mb();
        test_back_to_back();
        test_sat_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
